// File: rtl/mult_operand_issue.sv
// Issue stage for the sequential 16x16 multiplier: buffers tagged operand pairs in a FIFO,
// launches one multiply at a time and returns products in order on a valid/ready port.
module mult_operand_issue #(
  parameter int unsigned Depth = 4,
  parameter int unsigned TagW  = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [15:0]              in_multiplier_i,
  input  logic [15:0]              in_multiplicand_i,
  output logic                     mul_start_o,
  output logic [15:0]              mul_multiplier_o,
  output logic [15:0]              mul_multiplicand_o,
  input  logic                     mul_done_i,
  input  logic [31:0]              mul_product_i,
  output logic                     res_valid_o,
  input  logic                     res_ready_i,
  output logic [31:0]              res_product_o,
  output logic [TagW-1:0]          res_tag_o,
  output logic [$clog2(Depth):0]   fifo_count_o,
  output logic                     err_spurious_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StHold} state_e;

  logic [15:0]     fifo_a_q [Depth];
  logic [15:0]     fifo_b_q [Depth];
  logic [TagW-1:0] fifo_t_q [Depth];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [TagW-1:0] tag_q, tag_d;

  state_e          state_q, state_d;
  logic [15:0]     mul_a_q, mul_a_d;
  logic [15:0]     mul_b_q, mul_b_d;
  logic            mul_start_q, mul_start_d;
  logic            res_valid_q, res_valid_d;
  logic [31:0]     res_product_q, res_product_d;
  logic [TagW-1:0] res_tag_q, res_tag_d;
  logic            err_q, err_d;

  logic            push;
  logic            pop;
  logic [15:0]     head_a;
  logic [15:0]     head_b;
  logic [TagW-1:0] head_t;

  // Held low during reset so nothing is accepted while the FIFO is being cleared.
  assign in_ready_o = rst_ni & (count_q != CntW'(Depth));
  assign push       = in_valid_i & in_ready_o;

  assign head_a = fifo_a_q[rd_ptr_q];
  assign head_b = fifo_b_q[rd_ptr_q];
  assign head_t = fifo_t_q[rd_ptr_q];

  // Storage needs no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_a_q[wr_ptr_q] <= in_multiplier_i;
      fifo_b_q[wr_ptr_q] <= in_multiplicand_i;
      fifo_t_q[wr_ptr_q] <= tag_q;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    tag_d    = tag_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
      tag_d    = tag_q + TagW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_comb begin
    state_d       = state_q;
    mul_a_d       = mul_a_q;
    mul_b_d       = mul_b_q;
    res_product_d = res_product_q;
    res_tag_d     = res_tag_q;
    pop           = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (count_q != '0) begin
          pop       = 1'b1;
          res_tag_d = head_t;
          // A zero operand makes the product trivially zero; skip the multiplier.
          if (head_a == 16'd0 || head_b == 16'd0) begin
            res_product_d = '0;
            state_d       = StHold;
          end else begin
            mul_a_d = head_a;
            mul_b_d = head_b;
            state_d = StIssue;
          end
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (mul_done_i) begin
          res_product_d = mul_product_i;
          state_d       = StHold;
        end
      end
      StHold: begin
        if (res_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    mul_start_d = (state_d == StIssue);
    res_valid_d = (state_d == StHold);
    err_d       = err_q | (mul_done_i & (state_q != StWait));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      tag_q         <= '0;
      state_q       <= StIdle;
      mul_a_q       <= '0;
      mul_b_q       <= '0;
      mul_start_q   <= 1'b0;
      res_valid_q   <= 1'b0;
      res_product_q <= '0;
      res_tag_q     <= '0;
      err_q         <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      tag_q         <= tag_d;
      state_q       <= state_d;
      mul_a_q       <= mul_a_d;
      mul_b_q       <= mul_b_d;
      mul_start_q   <= mul_start_d;
      res_valid_q   <= res_valid_d;
      res_product_q <= res_product_d;
      res_tag_q     <= res_tag_d;
      err_q         <= err_d;
    end
  end

  assign mul_start_o        = mul_start_q;
  assign mul_multiplier_o   = mul_a_q;
  assign mul_multiplicand_o = mul_b_q;
  assign res_valid_o        = res_valid_q;
  assign res_product_o      = res_product_q;
  assign res_tag_o          = res_tag_q;
  assign fifo_count_o       = count_q;
  assign err_spurious_o     = err_q;

endmodule

// File: tb/tb_mult_operand_issue.sv
// Scoreboard bench for mult_operand_issue with a behavioural multiplier of programmable latency.
module tb_mult_operand_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a, in_b;
  logic        mul_start;
  logic [15:0] mul_a, mul_b;
  logic        mul_done;
  logic [31:0] mul_product;
  logic        res_valid, res_ready;
  logic [31:0] res_product;
  logic [7:0]  res_tag;
  logic [2:0]  fifo_count;
  logic        err_spurious;

  always #5 clk = ~clk;

  mult_operand_issue #(.Depth(4), .TagW(8)) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .in_valid_i        (in_valid),
    .in_ready_o        (in_ready),
    .in_multiplier_i   (in_a),
    .in_multiplicand_i (in_b),
    .mul_start_o       (mul_start),
    .mul_multiplier_o  (mul_a),
    .mul_multiplicand_o(mul_b),
    .mul_done_i        (mul_done),
    .mul_product_i     (mul_product),
    .res_valid_o       (res_valid),
    .res_ready_i       (res_ready),
    .res_product_o     (res_product),
    .res_tag_o         (res_tag),
    .fifo_count_o      (fifo_count),
    .err_spurious_o    (err_spurious)
  );

  typedef struct packed {
    logic [31:0] p;
    logic [7:0]  t;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] tag_m;
  int         n_checks = 0;
  int         n_fail = 0;
  int         lat = 17;
  int         starts = 0;
  bit         inject = 0;
  bit         rand_ready = 0;
  bit         mbusy = 0;
  bit         mcheck = 0;
  logic [7:0] last_tag;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural multiplier: done pulse L cycles after the start cycle, product = a*b.
  initial begin
    logic [15:0] ma, mb;
    int          mcnt;
    ma = '0; mb = '0; mcnt = 0;
    mul_done = 1'b0;
    mul_product = '0;
    forever begin
      @(posedge clk);
      #1;
      mul_done = 1'b0;
      if (mbusy) begin
        if (mcheck) begin
          check("mul_a_stable", mul_a, ma);
          check("mul_b_stable", mul_b, mb);
        end
        mcnt--;
        if (mcnt == 0) begin
          mul_done = 1'b1;
          mul_product = 32'(ma) * 32'(mb);
          mbusy = 0;
        end
      end else if (inject) begin
        mul_done = 1'b1;
        mul_product = 32'hDEAD_BEEF;
        inject = 0;
      end
      if (mul_start) begin
        starts++;
        check("start_while_busy", mbusy, 0);
        mbusy = 1;
        mcheck = 1;
        ma = mul_a;
        mb = mul_b;
        mcnt = lat;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) res_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: pops the scoreboard on every output handshake and checks stall stability.
  initial begin
    bit          stall_prev;
    logic [31:0] sp;
    logic [7:0]  st;
    exp_t        e;
    stall_prev = 0; sp = '0; st = '0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (stall_prev) begin
          check("hold_valid", res_valid, 1);
          check("hold_product", res_product, sp);
          check("hold_tag", res_tag, st);
        end
        if (res_valid && res_ready) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_result: got product %0h tag %0h, none expected",
                     res_product, res_tag);
          end else begin
            e = exp_q.pop_front();
            check("res_product", res_product, e.p);
            check("res_tag", res_tag, e.t);
            last_tag = res_tag;
          end
        end
        stall_prev = res_valid && !res_ready;
        sp = res_product;
        st = res_tag;
      end else begin
        stall_prev = 0;
      end
    end
  end

  task automatic push(input logic [15:0] a, input logic [15:0] b);
    int   n;
    exp_t e;
    n = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 300) begin
        check("push_timeout", 1, 0);
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    e.p = 32'(a) * 32'(b);
    e.t = tag_m;
    exp_q.push_back(e);
    tag_m++;
    #1 in_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_done", exp_q.size(), 0);
    cycles(2);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!res_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("wait_valid", res_valid, 1);
  endtask

  // Asserts reset mid-cycle and checks the outputs clear without waiting for a clock edge.
  task automatic do_reset();
    #3;
    rst_n = 1'b0;
    mcheck = 0;
    in_valid = 1'b0;
    exp_q.delete();
    tag_m = '0;
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_mul_start", mul_start, 0);
    check("rst_mul_a", mul_a, 0);
    check("rst_mul_b", mul_b, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_product", res_product, 0);
    check("rst_res_tag", res_tag, 0);
    check("rst_err", err_spurious, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    cycles(1);
    check("post_rst_in_ready", in_ready, 1);
  endtask

  initial begin
    int s0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    res_ready = 1'b0;
    tag_m = '0;
    last_tag = '0;
    cycles(1);
    do_reset();

    // Single multiply with a stalled consumer.
    s0 = starts;
    lat = 17;
    push(16'd3, 16'd7);
    wait_valid();
    check("single_product", res_product, 21);
    cycles(3);
    res_ready = 1'b1;
    drain();
    check("single_starts", starts - s0, 1);

    // Zero bypass never touches the multiplier.
    do_reset();
    s0 = starts;
    res_ready = 1'b1;
    push(16'd0, 16'hFFFF);
    push(16'h1234, 16'd0);
    drain();
    check("zero_starts", starts - s0, 0);

    // Full FIFO: one pair in flight, four buffered.
    do_reset();
    res_ready = 1'b0;
    lat = 3;
    for (int i = 0; i < 5; i++) push(16'(i + 2), 16'(i + 11));
    cycles(10);
    check("full_count", fifo_count, 4);
    check("full_in_ready", in_ready, 0);
    res_ready = 1'b1;
    push(16'd100, 16'd200);
    drain();

    // Randomized traffic with random latency and consumer backpressure.
    rand_ready = 1;
    for (int i = 0; i < 60; i++) begin
      lat = $urandom_range(1, 12);
      push(($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom),
           ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom));
      cycles($urandom_range(0, 2));
    end
    rand_ready = 0;
    res_ready = 1'b1;
    drain();

    // Spurious done while idle is sticky and otherwise harmless.
    check("err_before_spurious", err_spurious, 0);
    inject = 1;
    cycles(3);
    check("err_after_spurious", err_spurious, 1);
    lat = 5;
    push(16'd5, 16'd9);
    drain();
    check("err_still_set", err_spurious, 1);

    // Reset during WAIT with two entries buffered; the orphaned done is spurious.
    do_reset();
    res_ready = 1'b0;
    lat = 20;
    push(16'd10, 16'd20);
    push(16'd11, 16'd21);
    push(16'd12, 16'd22);
    cycles(4);
    check("wait_fifo_count", fifo_count, 2);
    check("wait_busy", mbusy, 1);
    do_reset();
    cycles(25);
    check("err_after_abort", err_spurious, 1);
    check("abort_no_result", res_valid, 0);

    // Tag wrap over 257 pushes.
    do_reset();
    res_ready = 1'b1;
    lat = 1;
    for (int i = 0; i < 257; i++) push(16'd1, 16'd1);
    drain();
    check("tag_wrap_last", last_tag, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, test incomplete");
    $fatal(1, "watchdog");
  end

endmodule
